// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the native-bus to APB4 master bridge.
// State encoding, channel identifiers and width helpers.
package apb_bridge_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic {
        CH_RD = 1'b0,
        CH_WR = 1'b1
    } chan_e;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // A disabled timeout (0) still gets a 1-bit counter so the vector stays legal.
    function automatic int cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Native write/read request channels plus the APB4 master port of the bridge.
// master = bridge side, slave = requesters and APB fabric side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    localparam int STRB_W = DATA_W / 8;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_ack;
    logic              wr_err;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;
    logic              rd_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    logic              busy;

    modport master (
        input  wr_req, wr_addr, wr_data, wr_strb,
        output wr_ack, wr_err,
        input  rd_req, rd_addr,
        output rd_data, rd_ack, rd_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr,
        output busy
    );

    modport slave (
        output wr_req, wr_addr, wr_data, wr_strb,
        input  wr_ack, wr_err,
        output rd_req, rd_addr,
        input  rd_data, rd_ack, rd_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr,
        input  busy
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter: a masked requester is ineligible, and on
// contention the requester opposite the last grant wins.
module apb_rr_arbiter (
    input  logic req_a,
    input  logic req_b,
    input  logic mask_a,
    input  logic mask_b,
    input  logic last_a,
    output logic gnt_a,
    output logic gnt_b
);

    logic elig_a;
    logic elig_b;

    assign elig_a = req_a & ~mask_a;
    assign elig_b = req_b & ~mask_b;

    assign gnt_a = elig_a & (~elig_b | ~last_a);
    assign gnt_b = elig_b & (~elig_a |  last_a);

endmodule

// File: rtl/apb_master_bridge.sv
// Native write/read channels arbitrated onto one APB4 master port, with byte
// strobes, PSLVERR reporting, wait-state timeout and back-to-back transfers.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_master_bridge_if.master  bus
);

    localparam int              STRB_W  = strb_w(DATA_W);
    localparam int              CW      = cnt_w(TIMEOUT);
    localparam logic            TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0]   TO_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last_wr;
    chan_e         cur_ch;

    logic in_access, done, abort, finish;
    logic arb_en, take;
    logic mask_wr, mask_rd, gnt_wr, gnt_rd;

    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [STRB_W-1:0] ld_strb;

    assign in_access = (state == ST_ACCESS);
    assign done      = in_access & bus.pready;
    assign abort     = in_access & ~bus.pready & TO_EN & (cnt == TO_LAST);
    assign finish    = done | abort;

    // The channel finishing now has not yet seen its ack, so it is masked too;
    // the registered ack masks it for one more cycle while its req drops.
    assign mask_wr = bus.wr_ack | (finish & (cur_ch == CH_WR));
    assign mask_rd = bus.rd_ack | (finish & (cur_ch == CH_RD));

    apb_rr_arbiter u_arb (
        .req_a  (bus.wr_req),
        .req_b  (bus.rd_req),
        .mask_a (mask_wr),
        .mask_b (mask_rd),
        .last_a (last_wr),
        .gnt_a  (gnt_wr),
        .gnt_b  (gnt_rd)
    );

    assign arb_en = (state == ST_IDLE) | finish;
    assign take   = arb_en & (gnt_wr | gnt_rd);

    always_comb begin
        ld_addr  = bus.rd_addr;
        ld_wdata = '0;
        ld_strb  = '0;
        if (gnt_wr) begin
            ld_addr  = bus.wr_addr;
            ld_wdata = bus.wr_data;
            ld_strb  = bus.wr_strb;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_wr     <= 1'b0;
            cur_ch      <= CH_RD;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.paddr   <= '0;
            bus.pwdata  <= '0;
            bus.pstrb   <= '0;
            bus.wr_ack  <= 1'b0;
            bus.wr_err  <= 1'b0;
            bus.rd_ack  <= 1'b0;
            bus.rd_err  <= 1'b0;
            bus.rd_data <= '0;
            bus.busy    <= 1'b0;
        end else begin
            bus.wr_ack <= 1'b0;
            bus.wr_err <= 1'b0;
            bus.rd_ack <= 1'b0;
            bus.rd_err <= 1'b0;

            if (state == ST_SETUP) begin
                state       <= ST_ACCESS;
                bus.penable <= 1'b1;
                cnt         <= '0;
            end else if (in_access && !finish) begin
                cnt <= cnt + CW'(1);
            end

            if (finish) begin
                if (cur_ch == CH_WR) begin
                    bus.wr_ack <= 1'b1;
                    bus.wr_err <= abort | bus.pslverr;
                end else begin
                    bus.rd_ack <= 1'b1;
                    bus.rd_err <= abort | bus.pslverr;
                    if (done)
                        bus.rd_data <= bus.prdata;
                end
            end

            if (take) begin
                state       <= ST_SETUP;
                cur_ch      <= gnt_wr ? CH_WR : CH_RD;
                last_wr     <= gnt_wr;
                bus.psel    <= 1'b1;
                bus.penable <= 1'b0;
                bus.pwrite  <= gnt_wr;
                bus.paddr   <= ld_addr;
                bus.pwdata  <= ld_wdata;
                bus.pstrb   <= ld_strb;
                bus.busy    <= 1'b1;
            end else if (finish || (state != ST_SETUP && state != ST_ACCESS)) begin
                state       <= ST_IDLE;
                bus.psel    <= 1'b0;
                bus.penable <= 1'b0;
                bus.pwrite  <= 1'b0;
                bus.paddr   <= '0;
                bus.pwdata  <= '0;
                bus.pstrb   <= '0;
                bus.busy    <= 1'b0;
            end
        end
    end

endmodule
